s2p_frame: RTL and testbench

- Parametrised serial-to-parallel converter. Successor to the fixed 4-lane FFT input deserialiser.
- Collects LANES consecutive accepted samples into one parallel group, then presents the group on a flattened bus with a valid/ready handshake.
- Generates its own lane count; no external counter is required.
- Adds start-of-group resynchronisation, selectable lane ordering and back-pressure.
- Sits between the serial sample source and the radix-LANES butterfly stage of the FFT pipeline.

---
 rtl/fft_pkg.sv | 17 +
 rtl/s2p_frame.sv | 106 ++++++++++
 tb/tb_s2p_frame.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT-pipeline definitions: lane-ordering codes, default sample width, clog2.
// No logic; imported by the deserialiser and butterfly stages.
// No flow control of its own.
package fft_pkg;

   localparam int   WORDLENGTH_DEF = 16;
   localparam logic ORDER_NAT      = 1'b0;
   localparam logic ORDER_REV      = 1'b1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/s2p_frame.sv
// Serial-to-parallel deserialiser: packs LANES accepted samples into one output group.
// Latency: group valid 1 clk after the accept of its last sample.
// Backpressure: only the completing sample stalls while an unconsumed group is held.
module s2p_frame
   import fft_pkg::*;
#(
   parameter int WORDLENGTH = WORDLENGTH_DEF,
   parameter int LANES      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic                          in_sop,
   input  logic [WORDLENGTH-1:0]         in_data,
   output logic                          in_ready,
   input  logic                          order_rev,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES*WORDLENGTH-1:0]   out_data,
   output logic                          err_short
);

   localparam int               CNT_W = clog2(LANES);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(LANES - 1);

   logic [CNT_W-1:0]            cnt;
   logic [CNT_W-1:0]            cnt_nxt;
   logic [WORDLENGTH-1:0]       sh [LANES-1];
   logic [WORDLENGTH-1:0]       samp [LANES];
   logic [LANES*WORDLENGTH-1:0] group;
   logic [LANES*WORDLENGTH-1:0] out_data_nxt;
   logic                        out_valid_nxt;
   logic                        err_short_nxt;
   logic                        accept;

   // Only the group-completing sample must wait for the output register to free up.
   assign in_ready = !(cnt == LAST && out_valid && !out_ready);
   assign accept   = in_valid && in_ready;

   // After LANES-1 shifts sh[j] holds sample j; the live input is always the last sample.
   always_comb begin
      for (int j = 0; j < LANES - 1; j++) begin
         samp[j] = sh[j];
      end
      samp[LANES-1] = in_data;
   end

   always_comb begin
      group = '0;
      for (int k = 0; k < LANES; k++) begin
         group[k*WORDLENGTH +: WORDLENGTH] = (order_rev == ORDER_REV) ? samp[LANES-1-k] : samp[k];
      end
   end

   always_comb begin
      cnt_nxt       = cnt;
      out_valid_nxt = out_valid;
      out_data_nxt  = out_data;
      err_short_nxt = 1'b0;
      if (out_valid && out_ready) begin
         out_valid_nxt = 1'b0;
      end
      if (accept) begin
         if (in_sop) begin
            cnt_nxt       = CNT_W'(1);
            err_short_nxt = (cnt != '0);
         end else if (cnt == LAST) begin
            // A same-cycle consume is overridden here, giving back-to-back groups.
            cnt_nxt       = '0;
            out_valid_nxt = 1'b1;
            out_data_nxt  = group;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         err_short <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         out_valid <= out_valid_nxt;
         out_data  <= out_data_nxt;
         err_short <= err_short_nxt;
      end
   end

   // Stale samples of a discarded partial group are simply shifted out by the new group.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < LANES - 1; j++) begin
            sh[j] <= '0;
         end
      end else if (accept) begin
         for (int j = 0; j < LANES - 2; j++) begin
            sh[j] <= sh[j+1];
         end
         sh[LANES-2] <= in_data;
      end
   end

endmodule

// File: tb/tb_s2p_frame.sv
// Bench for s2p_frame: directed LANES=4 cases plus randomized LANES=8/12-bit traffic,
// both checked every cycle against a sample-list reference model.
module tb_s2p_frame;

   logic             clk;
   logic             rst;
   logic [1:0]       in_valid;
   logic [1:0]       in_sop;
   logic [1:0][15:0] in_data;
   logic [1:0]       in_ready;
   logic [1:0]       order_rev;
   logic [1:0]       out_valid;
   logic [1:0]       out_ready;
   logic [1:0]       err_short;
   logic [63:0]      od0;
   logic [95:0]      od1;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state, index 0 = LANES 4, index 1 = LANES 8
   logic [15:0]  part [2][8];
   int           pcnt [2];
   logic         mv   [2];
   logic [127:0] mdata[2];
   logic         merr [2];
   int           n_done[2];
   int           n_cons[2];

   s2p_frame #(.WORDLENGTH(16), .LANES(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_sop(in_sop[0]), .in_data(in_data[0]),
      .in_ready(in_ready[0]), .order_rev(order_rev[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(od0), .err_short(err_short[0])
   );

   s2p_frame #(.WORDLENGTH(12), .LANES(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_sop(in_sop[1]), .in_data(in_data[1][11:0]),
      .in_ready(in_ready[1]), .order_rev(order_rev[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(od1), .err_short(err_short[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Model: evaluated mid-cycle on stable inputs; predicts the state after the next edge.
   initial begin : model
      int           L;
      int           W;
      logic         erdy;
      logic         acc;
      logic         cons;
      logic         nerr;
      logic [127:0] g;
      logic [127:0] dout;
      logic [15:0]  smp;
      for (int d = 0; d < 2; d++) begin
         pcnt[d] = 0; mv[d] = 1'b0; mdata[d] = '0; merr[d] = 1'b0;
         n_done[d] = 0; n_cons[d] = 0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            L = (d == 0) ? 4 : 8;
            W = (d == 0) ? 16 : 12;
            if (rst) begin
               pcnt[d] = 0; mv[d] = 1'b0; mdata[d] = '0; merr[d] = 1'b0;
            end else begin
               dout = (d == 0) ? 128'(od0) : 128'(od1);
               erdy = !(pcnt[d] == L - 1 && mv[d] && !out_ready[d]);
               check_eq($sformatf("in_ready%0d", d), 128'(in_ready[d]), 128'(erdy));
               check_eq($sformatf("out_valid%0d", d), 128'(out_valid[d]), 128'(mv[d]));
               check_eq($sformatf("err_short%0d", d), 128'(err_short[d]), 128'(merr[d]));
               check_eq($sformatf("out_data%0d", d), dout, mdata[d]);
               acc  = in_valid[d] && erdy;
               cons = mv[d] && out_ready[d];
               nerr = acc && in_sop[d] && pcnt[d] != 0;
               smp  = in_data[d] & 16'((1 << W) - 1);
               if (cons) begin
                  mv[d] = 1'b0;
                  n_cons[d]++;
               end
               if (acc) begin
                  if (in_sop[d]) begin
                     part[d][0] = smp;
                     pcnt[d] = 1;
                  end else begin
                     part[d][pcnt[d]] = smp;
                     pcnt[d]++;
                     if (pcnt[d] == L) begin
                        g = '0;
                        for (int k = 0; k < L; k++) begin
                           g |= 128'(part[d][order_rev[d] ? L - 1 - k : k]) << (k * W);
                        end
                        mdata[d] = g;
                        mv[d] = 1'b1;
                        pcnt[d] = 0;
                        n_done[d]++;
                     end
                  end
               end
               merr[d] = nerr;
            end
         end
      end
   end

   task automatic send0(input logic s, input logic [15:0] dat);
      in_valid[0] = 1'b1;
      in_sop[0]   = s;
      in_data[0]  = dat;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      in_sop[0]   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin : stim
      in_valid = '0; in_sop = '0; in_data = '0; order_rev = '0; out_ready = 2'b11;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);
      check_eq("reset_valid", 128'(out_valid[0]), 128'(0));
      check_eq("reset_data", 128'(od0), 128'(0));

      // natural order, continuous stream of two groups
      for (int i = 1; i <= 8; i++) begin
         send0(i == 1, 16'(i));
         if (i == 4) check_eq("nat_g0", 128'(od0), 128'(64'h0004_0003_0002_0001));
         if (i == 8) check_eq("nat_g1", 128'(od0), 128'(64'h0008_0007_0006_0005));
      end
      idle(2);

      // reversed order
      order_rev[0] = 1'b1;
      for (int i = 1; i <= 4; i++) send0(i == 1, 16'(i));
      check_eq("rev_g0", 128'(od0), 128'(64'h0001_0002_0003_0004));
      order_rev[0] = 1'b0;
      idle(2);

      // resync: short group discarded
      send0(1'b0, 16'h00A0);
      send0(1'b0, 16'h00A1);
      send0(1'b1, 16'h00B0);
      check_eq("resync_err", 128'(err_short[0]), 128'(1));
      send0(1'b0, 16'h00B1);
      check_eq("resync_err_clr", 128'(err_short[0]), 128'(0));
      send0(1'b0, 16'h00B2);
      send0(1'b0, 16'h00B3);
      check_eq("resync_grp", 128'(od0), 128'(64'h00B3_00B2_00B1_00B0));
      idle(2);

      // back-pressure on the completing sample only
      out_ready[0] = 1'b0;
      for (int i = 0; i < 4; i++) send0(i == 0, 16'h00C0 + 16'(i));
      for (int i = 0; i < 3; i++) begin
         check_eq("bp_flow_rdy", 128'(in_ready[0]), 128'(1));
         send0(i == 0, 16'h00D0 + 16'(i));
      end
      in_valid[0] = 1'b1;
      in_data[0]  = 16'h00D3;
      for (int i = 0; i < 3; i++) begin
         check_eq("bp_stall_rdy", 128'(in_ready[0]), 128'(0));
         check_eq("bp_hold", 128'(od0), 128'(64'h00C3_00C2_00C1_00C0));
         @(posedge clk); #1;
      end
      out_ready[0] = 1'b1;
      #1;
      check_eq("bp_release_rdy", 128'(in_ready[0]), 128'(1));
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      check_eq("bp_next_valid", 128'(out_valid[0]), 128'(1));
      check_eq("bp_next_grp", 128'(od0), 128'(64'h00D3_00D2_00D1_00D0));
      idle(2);

      // reset mid-group
      send0(1'b1, 16'h00E0);
      send0(1'b0, 16'h00E1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check_eq("rst_mid_valid", 128'(out_valid[0]), 128'(0));
      check_eq("rst_mid_data", 128'(od0), 128'(0));
      for (int i = 0; i < 4; i++) begin
         send0(1'b0, 16'h00F0 + 16'(i));
         check_eq("rst_mid_err", 128'(err_short[0]), 128'(0));
      end
      check_eq("rst_mid_grp", 128'(od0), 128'(64'h00F3_00F2_00F1_00F0));
      idle(2);

      // randomized traffic on the 8-lane instance
      for (int c = 0; c < 60000 && n_done[1] < 1000; c++) begin
         in_valid[1]  = ($urandom_range(0, 3) != 0);
         in_sop[1]    = ($urandom_range(0, 40) == 0);
         in_data[1]   = 16'($urandom) & 16'h0FFF;
         order_rev[1] = 1'($urandom);
         out_ready[1] = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      in_valid[1] = 1'b0; in_sop[1] = 1'b0; out_ready[1] = 1'b1;
      idle(4);
      check_eq("rand_groups_done", 128'(n_done[1] >= 1000), 128'(1));
      check_eq("rand_drained", 128'(n_cons[1]), 128'(n_done[1]));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
